axi4lite_mem: RTL and testbench

AXI4LITE_MEM -- requirements
Module: axi4lite_mem

---
 rtl/axi4lite_mem.sv | 110 +++++++++++
 tb/tb_axi4lite_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem.sv
// axi4lite_mem: AXI4-Lite slave in front of a byte-writable synchronous memory
module axi4lite_mem #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    WRITE_EN  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         AWADDR,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [31:0]         ARADDR,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP
);
  localparam int NB = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'(NB);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  logic [DATA_W-1:0] mem_q [DEPTH];
  r_state_e          r_state_q, r_state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_hs, ar_ok;
  assign ARREADY = r_state_q == R_IDLE && !ARESET;
  assign RVALID  = r_state_q == R_DATA;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign ar_hs   = ARVALID && ARREADY;
  assign ar_ok   = {1'b0, ARADDR} < LIMIT;
  always_comb begin
    r_state_d = ar_hs ? R_DATA : (RVALID && RREADY) ? R_IDLE : r_state_q;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= ar_ok ? mem_q[ARADDR[OFF +: IW]] : '0;
        rresp_q <= ar_ok ? OKAY : SLVERR;
      end
    end
  end
  w_state_e          w_state_q, w_state_d;
  logic [31:0]       awaddr_q, c_addr;
  logic [DATA_W-1:0] wdata_q, c_data;
  logic [NB-1:0]     wstrb_q, c_strb;
  logic [1:0]        bresp_q;
  logic              aw_hs, w_hs, commit, wr_ok;
  assign AWREADY = (w_state_q == W_IDLE || w_state_q == W_HAVE_D) && !ARESET;
  assign WREADY  = (w_state_q == W_IDLE || w_state_q == W_HAVE_A) && !ARESET;
  assign BVALID  = w_state_q == W_RESP;
  assign BRESP   = bresp_q;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign c_addr  = aw_hs ? AWADDR : awaddr_q;
  assign c_data  = w_hs ? WDATA : wdata_q;
  assign c_strb  = w_hs ? WSTRB : wstrb_q;
  assign wr_ok   = WRITE_EN != 0 && {1'b0, c_addr} < LIMIT;
  assign commit  = w_state_d == W_RESP && w_state_q != W_RESP;
  always_comb begin
    w_state_d = w_state_q;
    if (w_state_q == W_RESP)
      w_state_d = BREADY ? W_IDLE : W_RESP;
    else if ((aw_hs || w_state_q == W_HAVE_A) && (w_hs || w_state_q == W_HAVE_D))
      w_state_d = W_RESP;
    else if (aw_hs)
      w_state_d = W_HAVE_A;
    else if (w_hs)
      w_state_d = W_HAVE_D;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) awaddr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
    end
  end
  always_ff @(posedge ACLK) begin
    if (!ARESET && commit && wr_ok)
      for (int i = 0; i < NB; i++)
        if (c_strb[i]) mem_q[c_addr[OFF +: IW]][8*i +: 8] <= c_data[8*i +: 8];
  end
endmodule

// File: tb/tb_axi4lite_mem.sv
// tb_axi4lite_mem: directed bench driving a 32-bit RAM, a 64-bit RAM and a 32-bit ROM
// from one shared AXI4-Lite master.
module tb_axi4lite_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = 32'h0, araddr = 32'h0;
    logic [63:0] wdata = 64'h0;
    logic [7:0]  wstrb = 8'h0;

    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic [1:0]  w_bresp, w_rresp;
    logic [63:0] w_rdata;
    logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic [1:0]  mb, wb, rb, mr, wrs, rr;
    logic [31:0] md;
    logic [63:0] wd;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    axi4lite_mem #(.DATA_W(32), .DEPTH(1024)) u_m (
        .ACLK(clk), .ARESET(rst),
        .AWVALID(awvalid), .AWREADY(m_awready), .AWADDR(awaddr),
        .WVALID(wvalid), .WREADY(m_wready), .WDATA(wdata[31:0]), .WSTRB(wstrb[3:0]),
        .BVALID(m_bvalid), .BREADY(bready), .BRESP(m_bresp),
        .ARVALID(arvalid), .ARREADY(m_arready), .ARADDR(araddr),
        .RVALID(m_rvalid), .RREADY(rready), .RDATA(m_rdata), .RRESP(m_rresp));

    axi4lite_mem #(.DATA_W(64), .DEPTH(1024)) u_w (
        .ACLK(clk), .ARESET(rst),
        .AWVALID(awvalid), .AWREADY(w_awready), .AWADDR(awaddr),
        .WVALID(wvalid), .WREADY(w_wready), .WDATA(wdata), .WSTRB(wstrb),
        .BVALID(w_bvalid), .BREADY(bready), .BRESP(w_bresp),
        .ARVALID(arvalid), .ARREADY(w_arready), .ARADDR(araddr),
        .RVALID(w_rvalid), .RREADY(rready), .RDATA(w_rdata), .RRESP(w_rresp));

    axi4lite_mem #(.DATA_W(32), .DEPTH(16), .WRITE_EN(0)) u_r (
        .ACLK(clk), .ARESET(rst),
        .AWVALID(awvalid), .AWREADY(r_awready), .AWADDR(awaddr),
        .WVALID(wvalid), .WREADY(r_wready), .WDATA(wdata[31:0]), .WSTRB(wstrb[3:0]),
        .BVALID(r_bvalid), .BREADY(bready), .BRESP(r_bresp),
        .ARVALID(arvalid), .ARREADY(r_arready), .ARADDR(araddr),
        .RVALID(r_rvalid), .RREADY(rready), .RDATA(r_rdata), .RRESP(r_rresp));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // AW and W presented together; idle slaves accept both on the first edge.
    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", 64'(m_bvalid), 64'(1));
        mb = m_bresp; wb = w_bresp; rb = r_bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid", 64'(m_rvalid), 64'(1));
        md = m_rdata; wd = w_rdata; mr = m_rresp; wrs = w_rresp; rr = r_rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'({m_awready, m_wready, m_arready, w_awready, w_wready, w_arready,
                              r_awready, r_wready, r_arready}), 64'(0));
        chk("rst_valid", 64'({m_bvalid, m_rvalid, w_bvalid, w_rvalid, r_bvalid, r_rvalid}), 64'(0));
        chk("rst_resp", 64'({m_bresp, m_rresp, w_bresp, w_rresp, r_bresp, r_rresp}), 64'(0));
        chk("rst_rdata_m", 64'(m_rdata), 64'(0));
        chk("rst_rdata_w", w_rdata, 64'(0));
        chk("rst_rdata_r", 64'(r_rdata), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'({m_awready, m_wready, m_arready}), 64'(3'b111));

        wr(32'h10, 64'hDEADBEEF, 8'h0F);
        chk("wr10_bresp", 64'(mb), 64'(2'b00));
        chk("rom_wr10_bresp", 64'(rb), 64'(2'b10));
        rd(32'h10);
        chk("rd10_data", 64'(md), 64'h0000_0000_DEAD_BEEF);
        chk("rd10_resp", 64'(mr), 64'(2'b00));
        rd(32'h13);
        chk("rd13_unaligned", 64'(md), 64'h0000_0000_DEAD_BEEF);

        wr(32'h20, 64'h11223344, 8'h0F);
        wdata = 64'h0000AB00; wstrb = 8'h02; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("have_d_ready", 64'({m_awready, m_wready, m_bvalid}), 64'(3'b100));
        repeat (2) @(posedge clk);
        #1;
        awaddr = 32'h20; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("late_aw_bvalid", 64'(m_bvalid), 64'(1));
        chk("late_aw_bresp", 64'(m_bresp), 64'(2'b00));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_clear", 64'(m_bvalid), 64'(0));
        rd(32'h20);
        chk("rd20_merge", 64'(md), 64'h0000_0000_1122_AB44);

        wr(32'h0, 64'hCAFEF00D, 8'h0F);
        chk("rom_wr0_bresp", 64'(rb), 64'(2'b10));
        rd(32'h1000);
        chk("rd_oor_data", 64'(md), 64'(0));
        chk("rd_oor_resp", 64'(mr), 64'(2'b10));
        wr(32'h1000, 64'h12345678, 8'h0F);
        chk("wr_oor_bresp", 64'(mb), 64'(2'b10));
        rd(32'h0);
        chk("rd0_unchanged", 64'(md), 64'h0000_0000_CAFE_F00D);
        chk("rom_rd0_resp", 64'(rr), 64'(2'b00));
        wr(32'hFFC, 64'h55AA55AA, 8'h0F);
        chk("wr_last_bresp", 64'(mb), 64'(2'b00));
        rd(32'hFFC);
        chk("rd_last_data", 64'(md), 64'h0000_0000_55AA_55AA);

        araddr = 32'h10; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", 64'(m_rdata), 64'h0000_0000_DEAD_BEEF);
            chk("stall_flags", 64'({m_rvalid, m_arready, m_rresp}), 64'(4'b1000));
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("stall_release", 64'({m_rvalid, m_arready}), 64'(2'b01));

        wr(32'h30, 64'hAAAA0000, 8'h0F);
        awaddr = 32'h30; wdata = 64'hBBBB1111; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h30; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_edge_old", 64'(m_rdata), 64'h0000_0000_AAAA_0000);
        chk("same_edge_both", 64'({m_rvalid, m_bvalid}), 64'(2'b11));
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        rd(32'h30);
        chk("same_edge_new", 64'(md), 64'h0000_0000_BBBB_1111);
        awaddr = 32'h30; wdata = 64'hCCCC2222; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h30; arvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; bready = 1'b0;
        chk("next_edge_new", 64'(m_rdata), 64'h0000_0000_CCCC_2222);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;

        wr(32'h8, 64'h0, 8'hFF);
        wr(32'h8, 64'h89ABCDEF_01234567, 8'hF0);
        chk("strb0_bresp", 64'(mb), 64'(2'b00));
        chk("w64_bresp", 64'(wb), 64'(2'b00));
        rd(32'h8);
        chk("w64_upper", wd, 64'h89ABCDEF_00000000);
        chk("w64_resp", 64'(wrs), 64'(2'b00));
        chk("strb0_data", 64'(md), 64'(0));

        awaddr = 32'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("have_a_ready", 64'({w_awready, w_wready}), 64'(2'b01));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready", 64'({w_awready, w_wready, w_arready}), 64'(0));
        rst = 1'b0;
        wdata = 64'hFFFFFFFF_FFFFFFFF; wstrb = 8'hFF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("discard_no_bvalid", 64'({w_bvalid, m_bvalid}), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(32'h8);
        chk("discard_w64", wd, 64'h89ABCDEF_00000000);
        chk("discard_m", 64'(md), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
